lcd_frame_capture: RTL

- Sink side of the video controller's pixel output stream. Consumes the 2-bit pixel_data/pixel_latch stream with hsync/vsync framing and packs it into a 160x144 2bpp framebuffer.
- Packing is 4 pixels per byte, 40 bytes per line, 5760 bytes total, written through a valid/ready write port.
- Feeds the display scan-out / debug capture path and reports framing errors with sticky status flags.

---
 rtl/lcd_frame_capture.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_capture.sv
// Captures the 2bpp LCD pixel stream into a packed framebuffer (4 pixels/byte)
// through a small byte FIFO and a valid/ready write port, with sticky framing-error flags.
module lcd_frame_capture #(
  parameter int unsigned H_PIXELS   = 160,
  parameter int unsigned V_LINES    = 144,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pixel_data,
  input  logic              pixel_latch,
  input  logic              hsync,
  input  logic              vsync,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_wr,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              line_short,
  output logic              line_overflow,
  output logic              fifo_overrun,
  input  logic              clear_status
);

  localparam int unsigned BPL   = H_PIXELS / 4;
  localparam int unsigned X_W   = $clog2(H_PIXELS + 1);
  localparam int unsigned L_W   = $clog2(V_LINES + 1);
  localparam int unsigned P_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = P_W + 1;

  typedef enum logic [1:0] {WAIT_FRAME, CAPTURE, PAD, DRAIN} state_t;

  state_t             state;
  logic               hs_q, hs_qq, vs_q, vs_qq;
  logic [X_W-1:0]     x;
  logic [L_W-1:0]     line;
  logic [ADDR_W-1:0]  base;
  logic [7:0]         pack;
  logic               pad_drain;

  logic [ADDR_W-1:0]  mem_addr [FIFO_DEPTH];
  logic [7:0]         mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  logic               hs_rise, vs_rise, vs_fall;
  logic               fifo_empty, fifo_full, pop, has_room;
  logic               line_open, px_take, px_drop, pad_done;
  logic [X_W-1:0]     x_after, x_pad_next;
  logic [7:0]         pad_byte;
  logic               push_req, push_ok, overrun_set, short_set;
  logic [ADDR_W-1:0]  push_addr;
  logic [7:0]         push_data;

  // FIFO status and write port; a pop in the same cycle frees a slot for a push
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[P_W] != rd_ptr[P_W]) && (wr_ptr[P_W-1:0] == rd_ptr[P_W-1:0]);
  assign pop        = ~fifo_empty & fb_ready;
  assign has_room   = ~fifo_full | pop;
  assign fb_wr      = ~fifo_empty;
  assign fb_addr    = mem_addr[rd_ptr[P_W-1:0]];
  assign fb_data    = mem_data[rd_ptr[P_W-1:0]];

  // Pixel acceptance, padding and FIFO push selection
  always_comb begin
    hs_rise    = hs_q & ~hs_qq;
    vs_rise    = vs_q & ~vs_qq;
    vs_fall    = ~vs_q & vs_qq;
    line_open  = line < L_W'(V_LINES);
    px_take    = (state == CAPTURE) && pixel_latch && line_open && (x < X_W'(H_PIXELS));
    px_drop    = pixel_latch && ((state == PAD) ||
                 ((state == CAPTURE) && line_open && (x >= X_W'(H_PIXELS))));
    x_after    = px_take ? x + X_W'(1) : x;
    x_pad_next = (x | X_W'(3)) + X_W'(1);
    pad_done   = (x_pad_next == X_W'(H_PIXELS));
    case (x[1:0])
      2'd1:    pad_byte = {pack[1:0], 6'd0};
      2'd2:    pad_byte = {pack[3:0], 4'd0};
      2'd3:    pad_byte = {pack[5:0], 2'd0};
      default: pad_byte = 8'h00;
    endcase
    push_addr = base + ADDR_W'(x >> 2);
    push_req  = 1'b0;
    push_data = 8'h00;
    if (px_take && (x[1:0] == 2'd3)) begin
      push_req  = 1'b1;
      push_data = {pack[5:0], pixel_data};
    end else if ((state == PAD) && has_room) begin
      push_req  = 1'b1;
      push_data = pad_byte;
    end
    push_ok     = push_req & has_room;
    overrun_set = push_req & ~has_room;
    short_set   = (state == CAPTURE) && line_open &&
                  ((vs_rise && (x_after != '0) && (x_after < X_W'(H_PIXELS))) ||
                   (!vs_rise && hs_rise && (x_after != X_W'(H_PIXELS))));
  end

  // FIFO storage (no reset needed; validity is tracked by the pointers)
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_addr[wr_ptr[P_W-1:0]] <= push_addr;
      mem_data[wr_ptr[P_W-1:0]] <= push_data;
    end
  end

  // Framing FSM, pointers and status
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= WAIT_FRAME;
      hs_q          <= 1'b0;
      hs_qq         <= 1'b0;
      vs_q          <= 1'b0;
      vs_qq         <= 1'b0;
      x             <= '0;
      line          <= '0;
      base          <= '0;
      pack          <= '0;
      pad_drain     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      line_short    <= 1'b0;
      line_overflow <= 1'b0;
      fifo_overrun  <= 1'b0;
    end else begin
      hs_q  <= hsync;
      hs_qq <= hs_q;
      vs_q  <= vsync;
      vs_qq <= vs_q;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      frame_done    <= 1'b0;
      line_short    <= short_set   | (line_short    & ~clear_status);
      line_overflow <= px_drop     | (line_overflow & ~clear_status);
      fifo_overrun  <= overrun_set | (fifo_overrun  & ~clear_status);
      case (state)
        WAIT_FRAME: begin
          x         <= '0;
          line      <= '0;
          base      <= '0;
          pack      <= '0;
          pad_drain <= 1'b0;
          if (vs_fall && enable) state <= CAPTURE;
        end
        CAPTURE: begin
          if (px_take) begin
            pack <= {pack[5:0], pixel_data};
            x    <= x_after;
          end
          if (vs_rise) begin
            if (line_open && (x_after != '0) && (x_after < X_W'(H_PIXELS))) begin
              state     <= PAD;
              pad_drain <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (hs_rise && line_open) begin
            if (x_after == X_W'(H_PIXELS)) begin
              base <= base + ADDR_W'(BPL);
              line <= line + L_W'(1);
              x    <= '0;
              pack <= '0;
            end else begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (vs_rise) pad_drain <= 1'b1;
          if (has_room) begin
            if (pad_done) begin
              base  <= base + ADDR_W'(BPL);
              line  <= line + L_W'(1);
              x     <= '0;
              pack  <= '0;
              state <= (pad_drain || vs_rise) ? DRAIN : CAPTURE;
            end else begin
              x <= x_pad_next;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            state       <= WAIT_FRAME;
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule
